// File: rtl/inv_shift_sub_unit_pkg.sv
// Shared AES decryption definitions: FSM states, state geometry and the
// InvShiftRows byte-index mapping.
package aes_dec_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_e;

    // Source byte index for output byte idx (idx = 4c+r) under InvShiftRows:
    // s'[r][c] = s[r][(c-r) mod 4].
    function automatic int unsigned inv_shift_src(input int unsigned idx);
        int unsigned r;
        int unsigned c;
        r = idx % 4;
        c = idx / 4;
        return 4 * ((c + 4 - r) % 4) + r;
    endfunction

endpackage

// File: rtl/inv_shift_sub_unit_if.sv
// Handshake bundle for the InvShiftRows/InvSubBytes stage. The slave side is
// the unit itself; the master side drives input data and output acceptance.
interface inv_shift_sub_unit_if;
    import aes_dec_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_state;
    logic                   busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/inv_shift_sub_unit_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8)
// multiplicative inverse (0 maps to 0).
module InverseSbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128, which is the inverse for x != 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] affine_inv;

    // Inverse affine (rotl 1, 3, 6 plus 0x05) then field inverse.
    always_comb begin
        affine_inv = {byte_i[1:0], byte_i[7:2]}
                   ^ {byte_i[4:0], byte_i[7:5]}
                   ^ {byte_i[6:0], byte_i[7]}
                   ^ 8'h05;
        byte_o     = gf_inv(affine_inv);
    end

endmodule

// File: rtl/inv_shift_sub_unit.sv
// Sequential InvShiftRows + InvSubBytes: InvShiftRows at capture, then
// LANES bytes per cycle through InverseSbox until all 16 are substituted.
module inv_shift_sub_unit
    import aes_dec_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input logic                clk,
    input logic                rst,
    inv_shift_sub_unit_if.slave bus
);

    localparam int unsigned NGRP  = AES_BYTES / LANES;
    localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    state_e                 state_q, state_d;
    logic [GRP_W-1:0]       grp_q, grp_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] shifted;
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];

    // InvShiftRows of the incoming state, ready for capture.
    always_comb begin
        shifted = '0;
        for (int unsigned i = 0; i < AES_BYTES; i++) begin
            shifted[AES_STATE_W-1-8*i -: 8] =
                bus.in_state[AES_STATE_W-1-8*inv_shift_src(i) -: 8];
        end
    end

    // Select the current group of work bytes for the S-box lanes.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[AES_STATE_W-1-8*(32'(grp_q)*LANES+l) -: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        InverseSbox u_sbox (
            .byte_i (lane_in[g]),
            .byte_o (lane_out[g])
        );
    end

    // Next-state, group counter and work register update.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = shifted;
                    grp_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    work_d[AES_STATE_W-1-8*(32'(grp_q)*LANES+l) -: 8] = lane_out[l];
                end
                if (grp_q == GRP_W'(NGRP - 1)) begin
                    grp_d   = '0;
                    state_d = DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset discarding any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            work_q  <= work_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_state = work_q;

endmodule

// File: tb/tb_inv_shift_sub_unit.sv
// Directed bench for inv_shift_sub_unit with LANES = 4 (main) plus LANES = 1
// and 16 for the latency sweep.
module tb_inv_shift_sub_unit;

    localparam logic [127:0] ZERO_VEC = 128'h0;
    localparam logic [127:0] ZERO_EXP = {16{8'h52}};
    localparam logic [127:0] CNT_VEC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CNT_EXP  = 128'h52f3a3383009d79ebf366afb8140a5d5;
    localparam int           LAT_MAX  = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         sweep_en;
    logic [127:0] in_state;
    logic         out_ready;

    int errors = 0;
    int checks = 0;

    inv_shift_sub_unit_if if4 ();
    inv_shift_sub_unit_if if1 ();
    inv_shift_sub_unit_if if16 ();

    assign if4.in_valid   = in_valid;
    assign if4.in_state   = in_state;
    assign if4.out_ready  = out_ready;
    assign if1.in_valid   = in_valid & sweep_en;
    assign if1.in_state   = in_state;
    assign if1.out_ready  = out_ready;
    assign if16.in_valid  = in_valid & sweep_en;
    assign if16.in_state  = in_state;
    assign if16.out_ready = out_ready;

    inv_shift_sub_unit #(.LANES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    inv_shift_sub_unit #(.LANES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    inv_shift_sub_unit #(.LANES(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block to the LANES=4 unit and count edges until out_valid.
    task automatic run4(input string tag, input logic [127:0] vec, input logic [127:0] exp);
        int lat;
        check({tag, "_in_ready"}, 128'(if4.in_ready), 128'(1));
        in_state = vec;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < LAT_MAX) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(4));
        check({tag, "_out_state"}, if4.out_state, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat1;
        int lat4;
        int lat16;
        logic [127:0] res1;
        logic [127:0] res4;
        logic [127:0] res16;

        rst       = 1'b1;
        sweep_en  = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;

        // Reset held 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom);
            tick();
            check("rst_out_valid", 128'(if4.out_valid), 128'(0));
            check("rst_busy", 128'(if4.busy), 128'(0));
            check("rst_in_ready", 128'(if4.in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b0;
        #1;
        check("rel_in_ready", 128'(if4.in_ready), 128'(1));
        check("rel_work_zero", if4.out_state, ZERO_VEC);

        // All-zero and counting vectors.
        run4("zero", ZERO_VEC, ZERO_EXP);
        tick();
        check("zero_back_idle", 128'(if4.in_ready), 128'(1));
        run4("count", CNT_VEC, CNT_EXP);
        tick();

        // Backpressure: hold out_ready low for 10 cycles, pulse in_valid.
        out_ready = 1'b0;
        run4("bp", CNT_VEC, CNT_EXP);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = {16{8'hff}};
            tick();
            check("bp_out_valid", 128'(if4.out_valid), 128'(1));
            check("bp_out_state", if4.out_state, CNT_EXP);
            check("bp_in_ready", 128'(if4.in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 128'(if4.in_ready), 128'(1));
        check("bp_release_out_valid", 128'(if4.out_valid), 128'(0));
        run4("bp_next", ZERO_VEC, ZERO_EXP);
        tick();

        // Reset mid-SUB at grp = 2.
        check("mid_in_ready", 128'(if4.in_ready), 128'(1));
        in_state = CNT_VEC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy_before", 128'(if4.busy), 128'(1));
        rst = 1'b1;
        tick();
        check("mid_out_valid", 128'(if4.out_valid), 128'(0));
        check("mid_busy", 128'(if4.busy), 128'(0));
        check("mid_work_zero", if4.out_state, ZERO_VEC);
        check("mid_in_ready_rst", 128'(if4.in_ready), 128'(0));
        rst = 1'b0;
        #1;
        check("mid_in_ready_rel", 128'(if4.in_ready), 128'(1));
        run4("mid_zero", ZERO_VEC, ZERO_EXP);
        tick();

        // Parameter sweep: LANES = 1, 4, 16 with the counting vector.
        sweep_en = 1'b1;
        check("sw_ready1", 128'(if1.in_ready), 128'(1));
        check("sw_ready16", 128'(if16.in_ready), 128'(1));
        in_state = CNT_VEC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat1  = -1;
        lat4  = -1;
        lat16 = -1;
        res1  = '0;
        res4  = '0;
        res16 = '0;
        for (int n = 1; n <= LAT_MAX; n++) begin
            tick();
            if (if1.out_valid && lat1 < 0) begin
                lat1 = n;
                res1 = if1.out_state;
            end
            if (if4.out_valid && lat4 < 0) begin
                lat4 = n;
                res4 = if4.out_state;
            end
            if (if16.out_valid && lat16 < 0) begin
                lat16 = n;
                res16 = if16.out_state;
            end
            if (lat1 >= 0 && lat4 >= 0 && lat16 >= 0) break;
        end
        check("sw_lat1", 128'(lat1), 128'(16));
        check("sw_lat4", 128'(lat4), 128'(4));
        check("sw_lat16", 128'(lat16), 128'(1));
        check("sw_res1", res1, CNT_EXP);
        check("sw_res4", res4, CNT_EXP);
        check("sw_res16", res16, CNT_EXP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
